// File: rtl/ff_seq_pkg.sv
// Shared definitions for the set/clear/toggle flop command sequencer.
// Holds the {a,b} opcode encodings, the sequencer state encoding, and the
// next-state function of the downstream flop, which is used for the shadow model.
package ff_seq_pkg;

  // Opcodes are the literal {a,b} drive applied to the flop
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_TOG  = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Next q of the downstream flop: 00 hold, 11 set, 01 clear, 10 toggle
  function automatic logic next_q(input logic a, input logic b, input logic q);
    return (~a & ~b & q) | (a & b) | (a & ~q);
  endfunction

endpackage

// File: rtl/ff_seq_fifo.sv
// Synchronous command FIFO for the flop sequencer.
// Ports:
//   clk, rst_n   - clock, async active-low reset (flushes the FIFO)
//   push, wdata  - write request and data; push is ignored when the FIFO is full
//   pop, rdata   - pop request and head-of-queue data; pop is ignored when the FIFO is empty
//   full, empty  - occupancy flags, decoded from the registered count
module ff_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the registered count masks stale entries
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ff_cmd_sequencer.sv
// Command sequencer for the set/clear/toggle flop.
// Takes {op,cnt} commands through a valid/ready interface and queues them.
// Expands each command into cmd_cnt+1 cycles of {a,b} drive, and tracks a
// shadow copy of the flop's q. Any divergence from the real q_in is flagged
// on a sticky mismatch flag. After reset, one SYNC cycle drives CLEAR so that
// the unreset flop starts from a known 0.
// Ports:
//   clk, rst_n              - clock shared with the flop, async active-low reset
//   cmd_valid/ready/op/cnt  - command input handshake
//   a, b                    - registered flop drive
//   q_in                    - flop output
//   expected_q              - shadow q
//   mismatch, mismatch_clr  - sticky compare error and its clear
//   cmd_done                - one-cycle pulse after a command's final cycle
//   busy                    - high when not IDLE or when commands are queued
module ff_cmd_sequencer
  import ff_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             a,
  output logic             b,
  input  logic             q_in,
  output logic             expected_q,
  output logic             mismatch,
  input  logic             mismatch_clr,
  output logic             cmd_done,
  output logic             busy
);

  localparam int unsigned CMD_W = 2 + CNT_W;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic             a_nxt;
  logic             b_nxt;
  logic             done_nxt;
  logic             pop;
  logic             push;
  logic             check_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt;

  // Handshake and status are decoded from registers only
  assign cmd_ready = ~fifo_full & (state != ST_SYNC);
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign {head_op, head_cnt} = head;

  ff_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_op, cmd_cnt}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC: state_nxt = ST_IDLE;
      ST_IDLE: if (!fifo_empty) state_nxt = ST_RUN;
      ST_RUN:  if ((remaining == '0) && fifo_empty) state_nxt = ST_IDLE;
      default: state_nxt = ST_SYNC;
    endcase
  end

  // Output/datapath next values; a finished command chains straight into the next one
  always_comb begin
    pop           = 1'b0;
    a_nxt         = a;
    b_nxt         = b;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    case (state)
      ST_SYNC: {a_nxt, b_nxt} = OP_HOLD;
      ST_IDLE: begin
        {a_nxt, b_nxt} = OP_HOLD;
        if (!fifo_empty) begin
          pop            = 1'b1;
          {a_nxt, b_nxt} = head_op;
          remaining_nxt  = head_cnt;
        end
      end
      ST_RUN: begin
        if (remaining != '0) begin
          remaining_nxt = remaining - CNT_W'(1);
        end else begin
          done_nxt = 1'b1;
          if (!fifo_empty) begin
            pop            = 1'b1;
            {a_nxt, b_nxt} = head_op;
            remaining_nxt  = head_cnt;
          end else begin
            {a_nxt, b_nxt} = OP_HOLD;
          end
        end
      end
      default: {a_nxt, b_nxt} = OP_CLR;
    endcase
  end

  // Registered drive, shadow model and sticky checker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= 1'b0;
      b          <= 1'b1;
      remaining  <= '0;
      cmd_done   <= 1'b0;
      expected_q <= 1'b0;
      check_en   <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      a          <= a_nxt;
      b          <= b_nxt;
      remaining  <= remaining_nxt;
      cmd_done   <= done_nxt;
      // The SYNC cycle drives CLEAR, so the flop and the shadow both land on 0
      expected_q <= (state == ST_SYNC) ? 1'b0 : next_q(a, b, expected_q);
      check_en   <= check_en | (state == ST_SYNC);
      // A new error beats a simultaneous clear
      if (check_en && (q_in != expected_q)) mismatch <= 1'b1;
      else if (mismatch_clr)                mismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ff_cmd_sequencer.sv
// Testbench for ff_cmd_sequencer with a behavioural model of the unreset
// set/clear/toggle flop attached. Table rows give the inputs applied before
// an edge and the outputs expected just after it.
module tb_ff_cmd_sequencer;
  import ff_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_cnt = 4'd0;
  logic       a, b, q_in, expected_q, mismatch, cmd_done, busy;
  logic       mismatch_clr = 1'b0;
  logic       q_flop = 1'b0;
  logic       fault = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Downstream flop, no reset: 00 hold, 11 set, 01 clear, 10 toggle
  always @(posedge clk) begin
    case ({a, b})
      2'b00:   q_flop <= q_flop;
      2'b01:   q_flop <= 1'b0;
      2'b10:   q_flop <= ~q_flop;
      default: q_flop <= 1'b1;
    endcase
  end
  assign q_in = q_flop ^ fault;

  ff_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_cnt      (cmd_cnt),
    .a            (a),
    .b            (b),
    .q_in         (q_in),
    .expected_q   (expected_q),
    .mismatch     (mismatch),
    .mismatch_clr (mismatch_clr),
    .cmd_done     (cmd_done),
    .busy         (busy)
  );

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [3:0] cnt;
    logic       clr;
    logic       flt;
    logic [1:0] ab;
    logic       eq;
    logic       mm;
    logic       done;
    logic       rdy;
    logic       bsy;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input int valid, input int op, input int cnt, input int clr,
                              input int flt, input int ab, input int eq, input int mm,
                              input int done, input int rdy, input int bsy);
    vec_t v;
    v.valid = 1'(valid); v.op = 2'(op); v.cnt = 4'(cnt); v.clr = 1'(clr); v.flt = 1'(flt);
    v.ab = 2'(ab); v.eq = 1'(eq); v.mm = 1'(mm); v.done = 1'(done); v.rdy = 1'(rdy);
    v.bsy = 1'(bsy);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int ab, input int eq, input int mm,
                          input int done, input int rdy, input int bsy);
    chk({tag, ".ab"},   int'({a, b}),       ab);
    chk({tag, ".eq"},   int'(expected_q),   eq);
    chk({tag, ".mm"},   int'(mismatch),     mm);
    chk({tag, ".done"}, int'(cmd_done),     done);
    chk({tag, ".rdy"},  int'(cmd_ready),    rdy);
    chk({tag, ".busy"}, int'(busy),         bsy);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    //          vld op cnt clr flt | ab eq mm dn rdy busy
    vecs[0]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 0, 1, 0); // SYNC exit
    vecs[1]  = mk(1, 3, 0,  0, 0,   0, 0, 0, 0, 1, 1); // push SET cnt0
    vecs[2]  = mk(1, 2, 2,  0, 0,   3, 0, 0, 0, 1, 1); // push TOG cnt2, SET issued
    vecs[3]  = mk(0, 0, 0,  0, 0,   2, 1, 0, 1, 1, 1); // back-to-back TOG
    vecs[4]  = mk(0, 0, 0,  0, 0,   2, 0, 0, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0,  0, 0,   2, 1, 0, 0, 1, 1);
    vecs[6]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 1, 1, 0); // back to IDLE
    vecs[7]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, 3, 0,  0, 0,   0, 0, 0, 0, 1, 1); // SET
    vecs[9]  = mk(1, 0, 3,  0, 0,   3, 0, 0, 0, 1, 1); // HOLD cnt3
    vecs[10] = mk(0, 0, 0,  0, 0,   0, 1, 0, 1, 1, 1);
    vecs[11] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0, 1, 1);
    vecs[12] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0, 1, 1);
    vecs[13] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0, 1, 1);
    vecs[14] = mk(0, 0, 0,  0, 0,   0, 1, 0, 1, 1, 0);
    vecs[15] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0,  0, 1,   0, 1, 1, 0, 1, 0); // fault
    vecs[17] = mk(0, 0, 0,  0, 0,   0, 1, 1, 0, 1, 0); // sticky
    vecs[18] = mk(0, 0, 0,  1, 0,   0, 1, 0, 0, 1, 0); // clear
    vecs[19] = mk(0, 0, 0,  1, 1,   0, 1, 1, 0, 1, 0); // set beats clear
    vecs[20] = mk(0, 0, 0,  0, 0,   0, 1, 1, 0, 1, 0);
    vecs[21] = mk(0, 0, 0,  1, 0,   0, 1, 0, 0, 1, 0);
    vecs[22] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 1, 1); // backpressure: cmd 1
    vecs[23] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 1, 1); // cmd 1 to RUN, cmd 2 queued
    vecs[24] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 1, 1);
    vecs[25] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 1, 1);
    vecs[26] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 0, 1); // four queued: full
    vecs[27] = mk(1, 0, 15, 0, 0,   0, 1, 0, 0, 0, 1); // cmd 6 refused

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cmd_valid = vecs[i].valid; cmd_op = vecs[i].op; cmd_cnt = vecs[i].cnt;
      mismatch_clr = vecs[i].clr; fault = vecs[i].flt;
      @(posedge clk); #1;
      chk_outs($sformatf("v%0d", i), int'(vecs[i].ab), int'(vecs[i].eq), int'(vecs[i].mm),
               int'(vecs[i].done), int'(vecs[i].rdy), int'(vecs[i].bsy));
    end

    // cmd 6 is held; the first slot frees when cmd 1 (remaining 11) finishes
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) begin
        cyc = i;
        break;
      end
    end
    chk("bp.wait_cycles", cyc, 12);
    chk("bp.done_at_pop", int'(cmd_done), 1);
    @(posedge clk); #1;
    chk("bp.refull", int'(cmd_ready), 0);
    @(negedge clk);
    cmd_valid = 1'b0;

    // Clean reset, then reset in the middle of a TOG with two commands queued
    rst_n = 1'b0;
    #1;
    chk_outs("rst1", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_outs("rst1.sync", 0, 0, 0, 0, 1, 0);
    push_cmd(OP_TOG, 4'd10);
    push_cmd(OP_SET, 4'd0);
    push_cmd(OP_CLR, 4'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun.ab", int'({a, b}), int'(OP_TOG));
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_outs("midrst.sync", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_outs($sformatf("midrst.idle%0d", i), 0, 0, 0, 0, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
